// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 4-word lines and single-line AXI-bridge refill.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counter outputs.
module icache_dm #(
  parameter int INDEX_W = 6
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        flush,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = 28 - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [31:2]        req_addr_r;
  logic [1:0]         beat_cnt_r;
  logic               flush_pend_r;
  logic               init_done_r;
  logic [31:0]        line_buf_r [4];
  logic [LINES-1:0]   valid_r;
  logic [TAG_W-1:0]   tag_r [LINES];
  logic [31:0]        data_r [LINES][4];

  logic [INDEX_W-1:0] idx_s;
  logic [1:0]         off_s;
  logic [TAG_W-1:0]   tag_s;
  logic               hit_s;
  logic               accept_s;
  logic               fill_done_s;
  logic [31:0]        fill_s [4];
  logic               addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^addr[1:0];
  assign idx_s       = req_addr_r[INDEX_W+3:4];
  assign off_s       = req_addr_r[3:2];
  assign tag_s       = req_addr_r[31:INDEX_W+4];
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign accept_s    = addr_ok && req;
  assign fill_done_s = (state_r == S_REFILL) && ret_valid && ret_last;
  assign rd_type     = 3'b100;

  // Assemble the line being filled: received beats, the final beat, zeros for any missing words.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      if (w[1:0] < beat_cnt_r) begin
        fill_s[w] = line_buf_r[w];
      end else if (w[1:0] == beat_cnt_r) begin
        fill_s[w] = ret_data;
      end else begin
        fill_s[w] = 32'h0;
      end
    end
  end

  // Next-state and handshake outputs; rdata is a mux of registered storage only.
  always_comb begin
    state_s = state_r;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rd_req  = 1'b0;
    rdata   = 32'h0;
    rd_addr = 32'h0;
    case (state_r)
      S_IDLE: begin
        addr_ok = init_done_r;
        if (req && init_done_r) begin
          state_s = S_LOOKUP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit_s) begin
          data_ok = 1'b1;
          addr_ok = 1'b1;
          rdata   = data_r[idx_s][off_s];
          state_s = req ? S_LOOKUP : S_IDLE;
        end else begin
          state_s = S_MISS;
        end
      end
      S_MISS: begin
        rd_req  = 1'b1;
        rd_addr = {req_addr_r[31:4], 4'h0};
        if (rd_rdy) begin
          state_s = S_REFILL;
        end else begin
          state_s = S_MISS;
        end
      end
      S_REFILL: begin
        if (ret_valid && ret_last) begin
          state_s = S_RESP;
        end else begin
          state_s = S_REFILL;
        end
      end
      S_RESP: begin
        data_ok = 1'b1;
        rdata   = line_buf_r[off_s];
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Control state, request latch, beat counter, flush tracking and valid bits.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= S_IDLE;
      req_addr_r   <= 30'h0;
      beat_cnt_r   <= 2'd0;
      flush_pend_r <= 1'b0;
      init_done_r  <= 1'b0;
      valid_r      <= {LINES{1'b0}};
    end else begin
      state_r     <= state_s;
      init_done_r <= 1'b1;
      if (accept_s) begin
        req_addr_r <= addr[31:2];
      end
      if (state_r == S_MISS) begin
        beat_cnt_r <= 2'd0;
      end else if ((state_r == S_REFILL) && ret_valid) begin
        beat_cnt_r <= beat_cnt_r + 2'd1;
      end
      // A flush racing a refill must keep that line from being validated.
      if (state_s == S_IDLE) begin
        flush_pend_r <= 1'b0;
      end else if (flush && ((state_r == S_MISS) || (state_r == S_REFILL))) begin
        flush_pend_r <= 1'b1;
      end
      if (flush) begin
        valid_r <= {LINES{1'b0}};
      end
      if (fill_done_s) begin
        valid_r[idx_s] <= ~(flush_pend_r | flush);
      end
    end
  end

  // Refill beat buffer and line storage; contents are qualified by valid_r so need no reset.
  always_ff @(posedge aclk) begin
    if ((state_r == S_REFILL) && ret_valid) begin
      if (ret_last) begin
        for (int w = 0; w < 4; w++) begin
          line_buf_r[w] <= fill_s[w];
        end
      end else begin
        line_buf_r[beat_cnt_r] <= ret_data;
      end
    end
    if (fill_done_s) begin
      tag_r[idx_s] <= tag_s;
      for (int w = 0; w < 4; w++) begin
        data_r[idx_s][w] <= fill_s[w];
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Free-running hit/miss counters, wrapping naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else if (state_r == S_LOOKUP) begin
      if (hit_s) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: directed accesses push expected words, a monitor checks data_ok responses.
module tb_icache_dm;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  bit          rd_req_seen = 1'b0;
  int          dok_run = 0;
  int          dok_run_max = 0;

  always #5 aclk = ~aclk;

  icache_dm #(.INDEX_W(6)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       (req),
    .addr      (addr),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .flush     (flush),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  // Response monitor: pops one expected word per data_ok cycle.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && data_ok === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rdata_unexpected: got %h, required no response", rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rdata !== mon_exp) begin
          miscompares++;
          $display("FAIL rdata: got %h, required %h", rdata, mon_exp);
        end
      end
      dok_run++;
      if (dok_run > dok_run_max) dok_run_max = dok_run;
    end else begin
      dok_run = 0;
    end
    if (rd_req === 1'b1) rd_req_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string tag);
    chk({tag, "_addr_ok"}, 32'(addr_ok), 32'h0);
    chk({tag, "_data_ok"}, 32'(data_ok), 32'h0);
    chk({tag, "_rdata"},   rdata,        32'h0);
    chk({tag, "_rd_req"},  32'(rd_req),  32'h0);
    chk({tag, "_rd_type"}, 32'(rd_type), 32'h4);
    chk({tag, "_rd_addr"}, rd_addr,      32'h0);
  endtask

  // Present a request until accepted; returns at the negedge after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] e, input bit push);
    int n;
    if (push) exp_q.push_back(e);
    req  = 1'b1;
    addr = a;
    n = 0;
    while (addr_ok !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    if (addr_ok !== 1'b1) begin
      chk("addr_ok_timeout", 32'(addr_ok), 32'h1);
      req = 1'b0;
      return;
    end
    @(negedge aclk);
    req = 1'b0;
  endtask

  task automatic wait_rd_req(output bit ok);
    int n;
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      @(negedge aclk);
      n++;
    end
    ok = (rd_req === 1'b1);
    if (!ok) chk("rd_req_timeout", 32'(rd_req), 32'h1);
  endtask

  // Bridge model for one refill: optional stall before handshake, optional flush on a beat.
  task automatic serve(input logic [31:0] exp_ra, input logic [31:0] beats [4],
                       input int stall, input int flush_beat);
    bit ok;
    wait_rd_req(ok);
    if (!ok) return;
    chk("rd_addr", rd_addr, exp_ra);
    chk("rd_type", 32'(rd_type), 32'h4);
    for (int s = 0; s < stall; s++) begin
      rd_rdy = 1'b0;
      chk("stall_rd_req", 32'(rd_req), 32'h1);
      chk("stall_rd_addr", rd_addr, exp_ra);
      chk("stall_addr_ok", 32'(addr_ok), 32'h0);
      @(negedge aclk);
    end
    rd_rdy = 1'b1;
    @(negedge aclk);
    rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1'b1;
      ret_data  = beats[i];
      ret_last  = (i == 3);
      flush     = (i == flush_beat);
      @(negedge aclk);
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    flush     = 1'b0;
    chk("data_ok_after_last", 32'(data_ok), 32'h1);
  endtask

  initial begin
    bit ok;
    aresetn = 1'b0; req = 1'b0; addr = 32'h0; flush = 1'b0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    repeat (3) @(negedge aclk);
    check_reset("rst");
    aresetn = 1'b1;
    @(negedge aclk);
    chk("addr_ok_after_reset", 32'(addr_ok), 32'h1);

    // Cold miss
    issue(32'h1c00_0000, 32'h11, 1'b1);
    serve(32'h1c00_0000, '{32'h11, 32'h22, 32'h33, 32'h44}, 0, -1);

    // Back-to-back hit stream
    rd_req_seen = 1'b0;
    dok_run_max = 0;
    issue(32'h1c00_0004, 32'h22, 1'b1);
    issue(32'h1c00_0008, 32'h33, 1'b1);
    issue(32'h1c00_000c, 32'h44, 1'b1);
    repeat (2) @(negedge aclk);
    chk("hit_stream_rd_req", 32'(rd_req_seen), 32'h0);
    chk("hit_stream_run", 32'(dok_run_max), 32'd3);

    // Conflict eviction on index 0
    issue(32'h1c00_0400, 32'h55, 1'b1);
    serve(32'h1c00_0400, '{32'h55, 32'h66, 32'h77, 32'h88}, 0, -1);
    issue(32'h1c00_0000, 32'ha1, 1'b1);
    serve(32'h1c00_0000, '{32'ha1, 32'hb2, 32'hc3, 32'hd4}, 0, -1);

    // Stalled bridge, word 2 of index 1
    issue(32'h1c00_0018, 32'h30, 1'b1);
    serve(32'h1c00_0010, '{32'h10, 32'h20, 32'h30, 32'h40}, 5, -1);

    // Hit on the re-filled index 0 line
    rd_req_seen = 1'b0;
    issue(32'h1c00_0004, 32'hb2, 1'b1);
    repeat (2) @(negedge aclk);
    chk("refilled_hit_rd_req", 32'(rd_req_seen), 32'h0);

    // Flush on the second beat of a refill
    issue(32'h1c00_0024, 32'he1, 1'b1);
    serve(32'h1c00_0020, '{32'he0, 32'he1, 32'he2, 32'he3}, 0, 1);
    issue(32'h1c00_0024, 32'hf1, 1'b1);
    serve(32'h1c00_0020, '{32'hf0, 32'hf1, 32'hf2, 32'hf3}, 0, -1);
    issue(32'h1c00_0014, 32'h91, 1'b1);
    serve(32'h1c00_0010, '{32'h90, 32'h91, 32'h92, 32'h93}, 0, -1);

    // Reset after the first refill beat
    issue(32'h1c00_0030, 32'h0, 1'b0);
    wait_rd_req(ok);
    rd_rdy = 1'b1;
    @(negedge aclk);
    rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_data = 32'hc0; ret_last = 1'b0;
    @(negedge aclk);
    ret_valid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset("midfill_rst");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    issue(32'h1c00_0038, 32'hd2, 1'b1);
    serve(32'h1c00_0030, '{32'hd0, 32'hd1, 32'hd2, 32'hd3}, 0, -1);

    repeat (3) @(negedge aclk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
